instruction_fetch_unit: RTL

Pipeline stage 1. Fetches instructions from instruction memory and feeds instruction_decode_unit: instruction word, PC, and branch-predicted bit.
- Static backward-taken prediction for conditional branches.
- One-entry skid buffer absorbs a memory return during a downstream stall.
- Flush/redirect from execute discards wrong-path work.

---
 rtl/instruction_fetch_unit_pkg.sv | 35 +++
 rtl/instruction_fetch_unit_if.sv | 30 +++
 rtl/instruction_fetch_unit_skid.sv | 35 +++
 rtl/instruction_fetch_unit.sv | 105 ++++++++++
 4 files changed

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared fetch/decode constants, FSM state type, skid entry type and the static branch predictor.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package instruction_fetch_unit_pkg;

  localparam logic [31:0] NOP_ENC    = 32'h0000_0000;
  localparam int          PC_INDEX   = 31;          // register index that reads pc_o
  localparam int          OPC_HI     = 31;
  localparam int          OPC_LO     = 27;
  localparam int          IMM_HI     = 15;
  localparam int          IMM_LO     = 0;
  localparam logic [4:0]  OPC_BRANCH = 5'b11000;    // conditional branch

  typedef enum logic {
    S_FETCH   = 1'b0,
    S_DISCARD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;     // address of instr + 4
    logic        pred;
  } fetch_entry_t;

  // Backward-taken: a conditional branch with a negative immediate is predicted taken.
  function automatic logic is_pred_branch(input logic [31:0] w);
    return (w[OPC_HI:OPC_LO] == OPC_BRANCH) && w[IMM_HI];
  endfunction

  // Word-scaled, sign-extended branch displacement.
  function automatic logic [31:0] branch_offset(input logic [31:0] w);
    return {{14{w[IMM_HI]}}, w[IMM_HI:IMM_LO], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction memory request/ack plus the decode-facing outputs and controls.
// Latency: n/a (wiring only).
// Backpressure: decode stalls through stall_i; memory paces fetch through imem_ack_i.
interface instruction_fetch_unit_if;
  import instruction_fetch_unit_pkg::*;

  logic [31:0] imem_addr_o;
  logic        imem_req_o;
  logic [31:0] imem_data_i;
  logic        imem_ack_i;
  logic        stall_i;
  logic        flush_i;
  logic [31:0] flush_pc_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        branch_predicted_o;

  // Fetch unit side
  modport master (
    output imem_addr_o, imem_req_o, instruction_o, pc_o, branch_predicted_o,
    input  imem_data_i, imem_ack_i, stall_i, flush_i, flush_pc_i
  );

  // Memory / decode / execute side
  modport slave (
    input  imem_addr_o, imem_req_o, instruction_o, pc_o, branch_predicted_o,
    output imem_data_i, imem_ack_i, stall_i, flush_i, flush_pc_i
  );

endinterface

// File: rtl/instruction_fetch_unit_skid.sv
// One-entry skid buffer holding a fetched {instr, pc, pred} while decode is stalled.
// Latency: one cycle from load to valid_o.
// Backpressure: none internally; the fetch FSM never loads while an unrelated entry is pending.
module fetch_skid_buffer
  import instruction_fetch_unit_pkg::*;
(
  input  logic         clock_i,
  input  logic         reset_n_i,
  input  logic         load_i,
  input  logic         drain_i,
  input  fetch_entry_t entry_i,
  output logic         valid_o,
  output fetch_entry_t entry_o
);

  logic         valid_q;
  fetch_entry_t entry_q;

  // Load wins over drain so a drain-and-refill in the same cycle keeps the new entry
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      valid_q <= 1'b0;
      entry_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      entry_q <= entry_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign entry_o = entry_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Pipeline stage 1: fetches words from instruction memory, predicts backward branches, feeds decode.
// Latency: a memory ack in cycle N is on instruction_o after edge N; zero-wait memory sustains 1 instr/cycle.
// Backpressure: stall_i freezes outputs; one in-flight return is parked in the skid buffer, no new request until it drains.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD     = NOP_ENC
) (
  input  logic                      clock_i,
  input  logic                      reset_n_i,
  instruction_fetch_unit_if.master  bus
);

  fetch_state_e state_q;
  logic [31:0]  fetch_pc_q;
  logic [31:0]  stale_addr_q;
  fetch_entry_t out_q;

  logic         buf_valid;
  fetch_entry_t buf_entry;
  fetch_entry_t ack_entry;
  logic         req;
  logic         ack_acc;
  logic         pred_hit;
  logic         buf_load;
  logic         buf_drain;
  logic [31:0]  seq_pc;
  logic [31:0]  next_pc_d;
  logic [31:0]  addr;

  // A new request only starts with the buffer empty; DISCARD keeps the stale request alive until its ack
  assign req      = reset_n_i & ((state_q == S_DISCARD) | ~buf_valid);
  assign addr     = (state_q == S_DISCARD) ? stale_addr_q : fetch_pc_q;
  assign ack_acc  = bus.imem_ack_i & req & (state_q == S_FETCH) & ~bus.flush_i;
  assign pred_hit = is_pred_branch(bus.imem_data_i);
  assign seq_pc   = fetch_pc_q + 32'd4;
  assign next_pc_d = pred_hit ? (seq_pc + branch_offset(bus.imem_data_i)) : seq_pc;
  assign ack_entry = {bus.imem_data_i, seq_pc, pred_hit};

  // Park the return when decode cannot take it directly (stalled, or older word still buffered)
  assign buf_load  = ack_acc & (bus.stall_i | buf_valid);
  assign buf_drain = bus.flush_i | (~bus.stall_i & buf_valid);

  fetch_skid_buffer u_skid (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .load_i    (buf_load),
    .drain_i   (buf_drain),
    .entry_i   (ack_entry),
    .valid_o   (buf_valid),
    .entry_o   (buf_entry)
  );

  // Fetch FSM: advances the fetch PC on accepted acks and retires a stale request after a flush
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= S_FETCH;
      fetch_pc_q   <= RESET_VECTOR;
      stale_addr_q <= RESET_VECTOR;
    end else if (bus.flush_i) begin
      fetch_pc_q <= bus.flush_pc_i;
      if (req && !bus.imem_ack_i) begin
        state_q      <= S_DISCARD;
        stale_addr_q <= addr;   // keeps the address stable until memory completes
      end else begin
        state_q <= S_FETCH;
      end
    end else begin
      case (state_q)
        S_FETCH:   if (ack_acc) fetch_pc_q <= next_pc_d;
        S_DISCARD: if (bus.imem_ack_i) state_q <= S_FETCH;
        default:   state_q <= S_FETCH;
      endcase
    end
  end

  // Decode-facing register: buffered word first, then a direct ack, otherwise a bubble
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      out_q.instr <= NOP_WORD;
      out_q.pc    <= '0;
      out_q.pred  <= 1'b0;
    end else if (bus.flush_i) begin
      out_q.instr <= NOP_WORD;
      out_q.pred  <= 1'b0;
    end else if (!bus.stall_i) begin
      if (buf_valid) begin
        out_q <= buf_entry;
      end else if (ack_acc) begin
        out_q <= ack_entry;
      end else begin
        out_q.instr <= NOP_WORD;
        out_q.pred  <= 1'b0;
      end
    end
  end

  assign bus.imem_req_o         = req;
  assign bus.imem_addr_o        = addr;
  assign bus.instruction_o      = out_q.instr;
  assign bus.pc_o               = out_q.pc;
  assign bus.branch_predicted_o = out_q.pred;

endmodule
